// File: rtl/glitch_sweep_ctrl.sv
// Wishbone master that sweeps glitch_wb delay (inner loop) and width (outer loop), one attempt per point.
// Optional GLITCH_SWEEP_TRIG_EN: each attempt is armed only after a synchronized rising edge on trig_i.

`ifndef GLITCH_STATUS
`define GLITCH_STATUS  4'h0
`endif
`ifndef GLITCH_DELAY_0
`define GLITCH_DELAY_0 4'h1
`endif
`ifndef GLITCH_DELAY_1
`define GLITCH_DELAY_1 4'h2
`endif
`ifndef GLITCH_WIDTH
`define GLITCH_WIDTH   4'h3
`endif
`ifndef GLITCH_MODE
`define GLITCH_MODE    4'h4
`endif

module glitch_sweep_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned POLL_LIMIT  = 255,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  mode_i,
  input  logic [15:0] dly_first_i,
  input  logic [15:0] dly_last_i,
  input  logic [7:0]  dly_step_i,
  input  logic [7:0]  wid_first_i,
  input  logic [7:0]  wid_last_i,
  input  logic [7:0]  wid_step_i,
  input  logic        trig_i,
  output logic [5:2]  adr_o,
  output logic [7:0]  dat_o,
  input  logic [7:0]  dat_i,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        attempt_o,
  output logic [15:0] cur_dly_o,
  output logic [7:0]  cur_wid_o
);

  localparam int unsigned TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_D0, S_WR_D1, S_WR_WID, S_WAIT_TRIG,
    S_WR_ARM, S_GAP, S_RD_STAT, S_CHK, S_NEXT
  } state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_STB, PH_WAIT} phase_t;

  state_t            r_state;
  phase_t            r_phase;
  logic [TMO_W-1:0]  r_tmo;
  logic [POLL_W-1:0] r_poll;
  logic [GAP_W-1:0]  r_gap;
  logic              r_rdy;
  logic [5:2]        r_adr;
  logic [7:0]        r_dat;
  logic              r_we;
  logic              r_stb;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_attempt;
  logic [15:0]       r_cur_dly;
  logic [7:0]        r_cur_wid;

  logic [5:2]        w_adr;
  logic [7:0]        w_dat;
  logic              w_we;
  logic              w_bus_st;
  state_t            w_after;
  logic [15:0]       w_dly_step;
  logic [16:0]       w_dly_sum;
  logic              w_dly_end;
  logic [7:0]        w_wid_step;
  logic [8:0]        w_wid_sum;
  logic              w_wid_end;
  logic              w_trig_go;
  logic              w_unused;

  // Stepping: a zero step counts as one; passing last or carrying out ends the axis.
  assign w_dly_step = (dly_step_i == 8'd0) ? 16'd1 : {8'd0, dly_step_i};
  assign w_dly_sum  = {1'b0, r_cur_dly} + {1'b0, w_dly_step};
  assign w_dly_end  = w_dly_sum[16] | (w_dly_sum[15:0] > dly_last_i);
  assign w_wid_step = (wid_step_i == 8'd0) ? 8'd1 : wid_step_i;
  assign w_wid_sum  = {1'b0, r_cur_wid} + {1'b0, w_wid_step};
  assign w_wid_end  = w_wid_sum[8] | (w_wid_sum[7:0] > wid_last_i);

`ifdef GLITCH_SWEEP_TRIG_EN
  logic r_trig_s1;
  logic r_trig_s2;
  logic r_trig_d;

  // r_trig_d is held high outside WAIT_TRIG so only edges seen after entry count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_d  <= 1'b1;
    end else begin
      r_trig_s1 <= trig_i;
      r_trig_s2 <= r_trig_s1;
      r_trig_d  <= (r_state == S_WAIT_TRIG) ? r_trig_s2 : 1'b1;
    end
  end

  assign w_trig_go = r_trig_s2 & ~r_trig_d;
  assign w_unused  = ^dat_i[7:1];
`else
  assign w_trig_go = 1'b1;
  assign w_unused  = ^{dat_i[7:1], trig_i};
`endif

  // Bus cycle payload and successor for each bus-issuing state.
  always_comb begin
    w_adr    = `GLITCH_STATUS;
    w_dat    = 8'h00;
    w_we     = 1'b1;
    w_bus_st = 1'b1;
    w_after  = S_IDLE;
    case (r_state)
      S_WR_MODE: begin w_adr = `GLITCH_MODE;    w_dat = mode_i;           w_after = S_WR_D0;     end
      S_WR_D0:   begin w_adr = `GLITCH_DELAY_0; w_dat = r_cur_dly[7:0];   w_after = S_WR_D1;     end
      S_WR_D1:   begin w_adr = `GLITCH_DELAY_1; w_dat = r_cur_dly[15:8];  w_after = S_WR_WID;    end
      S_WR_WID:  begin w_adr = `GLITCH_WIDTH;   w_dat = r_cur_wid;        w_after = S_WAIT_TRIG; end
      S_WR_ARM:  begin w_dat = 8'h01;                                     w_after = S_GAP;       end
      S_RD_STAT: begin w_we = 1'b0;                                       w_after = S_CHK;       end
      default:   w_bus_st = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_phase   <= PH_ISSUE;
      r_tmo     <= '0;
      r_poll    <= '0;
      r_gap     <= '0;
      r_rdy     <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_stb     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_attempt <= 1'b0;
      r_cur_dly <= '0;
      r_cur_wid <= '0;
    end else begin
      r_stb     <= 1'b0;
      r_done    <= 1'b0;
      r_attempt <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start_i && !abort_i) begin
          r_err     <= 1'b0;
          r_cur_dly <= dly_first_i;
          r_cur_wid <= wid_first_i;
          r_busy    <= 1'b1;
          r_phase   <= PH_ISSUE;
          r_state   <= S_WR_MODE;
        end
      end else if (w_bus_st && r_phase != PH_ISSUE) begin
        // Outstanding bus cycle: abort is not sampled until it completes.
        if (r_phase == PH_STB) begin
          r_phase <= PH_WAIT;
          r_tmo   <= '0;
        end else if (ack_i) begin
          if (!r_we) r_rdy <= dat_i[0];
          if (r_state == S_WR_ARM) r_poll <= '0;
          r_gap   <= '0;
          r_phase <= PH_ISSUE;
          r_state <= w_after;
        end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_phase <= PH_ISSUE;
          r_state <= S_IDLE;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end else if (abort_i) begin
        r_busy  <= 1'b0;
        r_phase <= PH_ISSUE;
        r_state <= S_IDLE;
      end else if (w_bus_st) begin
        r_stb   <= 1'b1;
        r_adr   <= w_adr;
        r_dat   <= w_dat;
        r_we    <= w_we;
        r_phase <= PH_STB;
      end else begin
        case (r_state)
          S_WAIT_TRIG: if (w_trig_go) r_state <= S_WR_ARM;
          S_GAP: begin
            if (r_gap == GAP_W'(POLL_GAP - 1)) begin
              r_gap   <= '0;
              r_state <= S_RD_STAT;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
          S_CHK: begin
            if (r_rdy) begin
              r_attempt <= 1'b1;
              r_state   <= S_NEXT;
            end else if (r_poll == POLL_W'(POLL_LIMIT - 1)) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_poll  <= r_poll + POLL_W'(1);
              r_state <= S_GAP;
            end
          end
          S_NEXT: begin
            if (!w_dly_end) begin
              r_cur_dly <= w_dly_sum[15:0];
              r_state   <= S_WR_D0;
            end else if (!w_wid_end) begin
              r_cur_dly <= dly_first_i;
              r_cur_wid <= w_wid_sum[7:0];
              r_state   <= S_WR_D0;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign we_o      = r_we;
  assign stb_o     = r_stb;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign attempt_o = r_attempt;
  assign cur_dly_o = r_cur_dly;
  assign cur_wid_o = r_cur_wid;

endmodule
